// File: rtl/pp_sum_gen.sv
// Sum generator for a parallel-prefix adder: stage 1 forms the carry vector, stage 2 registers sum/cout.
// Optional signed-overflow output enabled by defining PP_SUM_OVF_EN.
module pp_sum_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_bit,
  input  logic [WIDTH-1:0] g_grp,
  input  logic [WIDTH-1:0] p_grp,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PP_SUM_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic             s1_adv, s2_adv;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH:0]   s1_c_q, s1_c_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef PP_SUM_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out
  always_comb begin
    carry[0]       = cin;
    carry[WIDTH:1] = g_grp | (p_grp & {WIDTH{cin}});
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = !rst && s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_c_d     = s1_c_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_p_d = p_bit;
        s1_c_d = carry;
      end
    end
  end

  // Output registers only reload on real data so an empty pipe keeps the last result visible
  always_comb begin
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
`ifdef PP_SUM_OVF_EN
    ovf_d      = ovf_q;
`endif
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = s1_p_q ^ s1_c_q[WIDTH-1:0];
        cout_d = s1_c_q[WIDTH];
`ifdef PP_SUM_OVF_EN
        ovf_d  = s1_c_q[WIDTH-1] ^ s1_c_q[WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
`ifdef PP_SUM_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_c_q     <= s1_c_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
`ifdef PP_SUM_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef PP_SUM_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pp_sum_gen.sv
// Directed bench for pp_sum_gen at WIDTH=4: reset, arithmetic vectors, backpressure, streaming, mid-run reset.
module tb_pp_sum_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] p_bit, g_grp, p_grp, sum;
`ifdef PP_SUM_OVF_EN
  logic         ovf;
`endif
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pp_sum_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_bit(p_bit), .g_grp(g_grp), .p_grp(p_grp), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef PP_SUM_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  // Build prefix-tree inputs from plain operands with a ripple recurrence
  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] g, p;
    logic gg, pp;
    g = a & b;
    p = a ^ b;
    gg = 1'b0;
    pp = 1'b1;
    for (int i = 0; i < W; i++) begin
      gg = g[i] | (p[i] & gg);
      pp = p[i] & pp;
      g_grp[i] = gg;
      p_grp[i] = pp;
    end
    p_bit = p;
    cin   = c;
  endtask

  function automatic logic [4:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {4'b0, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    set_ops(4'h3, 4'h4, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (sum !== 4'h0) begin bad++; $display("FAIL rst_sum: got %h want 0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_cout: got %b want 0", cout); end
`ifdef PP_SUM_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single(input logic [3:0] a, input logic [3:0] b, input logic c,
                             input logic [3:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    @(negedge clk);
    set_ops(a, b, c);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_accept: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", out_valid); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    total++; if (sum !== exp_sum) begin bad++; $display("FAIL single_sum: got %b want %b", sum, exp_sum); end
    total++; if (cout !== exp_cout) begin bad++; $display("FAIL single_cout: got %b want %b", cout, exp_cout); end
`ifdef PP_SUM_OVF_EN
    total++; if (ovf !== exp_ovf) begin bad++; $display("FAIL single_ovf: got %b want %b", ovf, exp_ovf); end
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_valid: got %b want 0", out_valid); end
    total++; if (sum !== exp_sum) begin bad++; $display("FAIL empty_hold_sum: got %b want %b", sum, exp_sum); end
  endtask

  task automatic test_backpressure();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic       vc [3];
    logic [4:0] e;
    logic [3:0] held;
    int sent, got;
    va = '{4'h1, 4'h2, 4'h3};
    vb = '{4'h6, 4'h9, 4'hF};
    vc = '{1'b0, 1'b1, 1'b1};
    sent = 0; got = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sent < 3) set_ops(va[sent], vb[sent], vc[sent]);
      in_valid = (sent < 3);
      #1;
      if (in_valid && in_ready) sent++;
    end
    total++; if (sent !== 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", sent); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    e = ref_add(va[0], vb[0], vc[0]);
    total++; if (sum !== e[3:0]) begin bad++; $display("FAIL bp_held_sum: got %h want %h", sum, e[3:0]); end
    held = sum;
    repeat (2) @(posedge clk);
    #1;
    total++; if (sum !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp_stable: got %h/%b want %h/1", sum, out_valid, held); end
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 3) set_ops(va[sent], vb[sent], vc[sent]);
      in_valid = (sent < 3);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        e = ref_add(va[got], vb[got], vc[got]);
        total++; if ({cout, sum} !== e) begin bad++; $display("FAIL bp_order_%0d: got %h want %h", got, {cout, sum}, e); end
        got++;
      end
    end
    in_valid = 1'b0;
    total++; if (got !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    logic [3:0] a, b;
    int sent, got, first_in, first_out, last_out;
    sent = 0; got = 0; first_in = 0; first_out = 0; last_out = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && got < 8; k++) begin
      @(negedge clk);
      if (sent < 8) begin
        a = 4'(sent * 3 + 1);
        b = 4'(sent * 5 + 2);
        set_ops(a, b, sent[0]);
      end
      in_valid = (sent < 8);
      #1;
      if (out_valid && out_ready) begin
        a = 4'(got * 3 + 1);
        b = 4'(got * 5 + 2);
        e = ref_add(a, b, got[0]);
        total++; if ({cout, sum} !== e) begin bad++; $display("FAIL b2b_%0d: got %h want %h", got, {cout, sum}, e); end
        if (got == 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        if (sent == 0) first_in = cyc;
        sent++;
      end
    end
    in_valid = 1'b0;
    total++; if (got !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got); end
    total++; if (last_out - first_out !== 7) begin bad++; $display("FAIL b2b_rate: got %0d want 7", last_out - first_out); end
    total++; if (first_out - first_in !== 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", first_out - first_in); end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_ops(4'(k + 7), 4'h5, 1'b1);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    total++; if (sum !== 4'h0) begin bad++; $display("FAIL mid_rst_sum: got %h want 0", sum); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale: got %0d want 0", stale); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    p_bit = '0; g_grp = '0; p_grp = '0; cin = 1'b0;
    test_reset();
    test_single(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    test_single(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pp_sum_gen.md
PP_SUM_GEN -- requirements
Module: pp_sum_gen

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand width in bits; legal range 2..64.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 in_valid  input  1  Upstream prefix tree offers a valid operand set this cycle.
REQ-005 in_ready  output  1  Block accepts the operand set this cycle.
REQ-006 p_bit  input  WIDTH  Bitwise propagate, a[i]^b[i].
REQ-007 g_grp  input  WIDTH  Group generate G[i:0] from the prefix tree, bit i.
REQ-008 p_grp  input  WIDTH  Group propagate P[i:0] from the prefix tree, bit i.
REQ-009 cin  input  1  Carry-in of the addition.
REQ-010 out_valid  output  1  Sum output is valid.
REQ-011 out_ready  input  1  Downstream accepts the sum.
REQ-012 sum  output  WIDTH  Registered sum.
REQ-013 cout  output  1  Registered carry-out.
REQ-014 ovf  output  1  Signed overflow; exists only under REQ-032.

Function
REQ-015 Carry into bit 0 SHALL be cin; carry into bit i (i>=1) SHALL be g_grp[i-1] | (p_grp[i-1] & cin).
REQ-016 sum[i] SHALL equal p_bit[i] ^ carry_i; cout SHALL equal g_grp[WIDTH-1] | (p_grp[WIDTH-1] & cin); no truncation or wrap beyond modulo-2^WIDTH.
REQ-017 The datapath SHALL be a two-stage pipeline: stage 1 registers p_bit and the carry vector, and stage 2 registers sum and cout; latency is 2 cycles from input handshake to out_valid when no backpressure occurs.
REQ-018 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-019 Stage 2 SHALL advance when s2_valid==0 or out_ready==1; stage 1 SHALL advance when s1_valid==0 or stage 2 advances; in_ready SHALL equal the stage-1 advance condition.
REQ-020 A stage holding valid data that cannot advance SHALL hold its contents unchanged; no data SHALL be dropped or duplicated.
REQ-021 Full condition (both stages valid, out_ready=0): in_ready=0 and sum/cout stable.
REQ-022 Simultaneous output handshake and input handshake in the same cycle SHALL both complete, sustaining 1 result per cycle.
REQ-023 Empty condition: out_valid=0; sum/cout hold their last values.
REQ-024 Results SHALL emerge in acceptance order.
REQ-025 The sum, cout, and ovf outputs SHALL be driven only from stage-2 registers.

Reset
REQ-026 While rst=1 at a clock edge, s1_valid, s2_valid, and out_valid SHALL be 0, and sum, cout, and ovf SHALL be 0.
REQ-027 in_ready SHALL be 0 while rst is asserted.
REQ-028 Reset mid-operation SHALL discard all in-flight results; no output handshake occurs for them.
REQ-029 On the first cycle after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-030 Macro PP_SUM_OVF_EN selects signed-overflow support.
REQ-031 Without PP_SUM_OVF_EN: no ovf port and no overflow logic.
REQ-032 With PP_SUM_OVF_EN: port ovf exists and is registered in stage 2 as carry_{WIDTH-1} ^ cout, with the same timing and reset as cout.

Verification (WIDTH=4)
REQ-033 Stimulus: a=0101, b=0011, cin=0 (p_bit=0110, g_grp=0111, p_grp=0000), single transfer. Response: 2 cycles later out_valid=1, sum=1000, cout=0, ovf=1.
REQ-034 Stimulus: a=1111, b=0000, cin=1 (p_bit=1111, g_grp=0000, p_grp=1111). Response: sum=0000, cout=1, ovf=0.
REQ-035 Stimulus: out_ready=0 while 3 back-to-back inputs are offered. Response: exactly 2 inputs are accepted, then in_ready=0; on raising out_ready, results emerge in order with none lost.
REQ-036 Stimulus: in_valid=1 and out_ready=1 continuously for 8 operand sets. Response: 8 results on consecutive cycles after the 2-cycle fill.
REQ-037 Stimulus: rst asserted with 2 results in flight. Response: out_valid=0 and sum=0 the next cycle; no stale result appears after release.
